game_state_ctrl: RTL
====================

Name: game_state_ctrl

Overview:
- Top-level game sequencer that sits directly upstream of gamelogic.
- Drives the Game_State and Dead signals that gamelogic turns into the sprite Restart (Restart = Reset | Game_State==START).
- Decodes keyboard presses into start/restart requests.
- Runs a once-per-frame bounding-box collision check of the runner against the cactus and pterosaur.

Parameters:
- KEY_START, 8'h28, keycode that starts or restarts the game (Enter).
- KEY_JUMP, 8'h2C, alternate start key (Space); also starts the game from START.
- DINO_W, 44, runner box width in pixels.
- DINO_H, 47, runner box height in pixels.
- PT_W, 46, pterosaur box width in pixels.
- PT_H, 40, pterosaur box height in pixels.
- HIT_FRAMES, 1, consecutive colliding frames needed to die (range 1..15).
- HOLDOFF_FRAMES, 30, frames after death during which restart presses are ignored (range 0..63).

Ports:
- Clk50  in  1  system clock; all state is on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- frame_Clk  in  1  frame strobe, asynchronous to Clk50; each rising edge is one frame.
- keycode  in  8  current USB keycode; 8'h00 means no key.
- Dino_PosX  in  10  runner top-left X.
- Dino_PosY  in  10  runner top-left Y.
- Cactus_PosX  in  10  cactus top-left X.
- Cactus_PosY  in  10  cactus top-left Y.
- Cactus_SizeX  in  10  cactus width in pixels.
- Cactus_SizeY  in  10  cactus height in pixels.
- Ptero_PosX  in  10  pterosaur top-left X.
- Ptero_PosY  in  10  pterosaur top-left Y.
- ca_off  in  1  cactus not on screen; excluded from collision.
- pt_off  in  1  pterosaur not on screen; excluded from collision.
- Game_State  out  2  00 START, 01 RUN, 10 DEAD.
- Dead  out  1  high while in DEAD.
- Enter  out  1  one-cycle pulse on a qualified KEY_START press.
- frame_tick  out  1  one-cycle pulse per synchronised frame_Clk rising edge.

Behaviour:
- Reset (async, active-high): Game_State=00, Dead=0, Enter=0, frame_tick=0; hit counter=0, holdoff counter=0, key history=00.
- Reset asserted mid-game returns to START immediately, from any state.
- frame_Clk passes through a 2-FF synchroniser, then a rising-edge detector.
- frame_tick fires 3 Clk50 cycles after the frame_Clk edge and lasts one cycle.
- Key press detection: press = (keycode==K) && (previous-cycle keycode!=K). Holding a key produces exactly one press.
- Enter = registered KEY_START press; 1-cycle latency after the keycode change.
- Collision is evaluated only on frame_tick while in RUN, using the input values present on that cycle.
- Overlap(A,B) = Ax < Bx+Bw && Bx < Ax+Aw && Ay < By+Bh && By < Ay+Ah.
- Overlap arithmetic uses 11 bits unsigned, so the sums never wrap.
- Edge-touching boxes (Ax+Aw == Bx) do not collide.
- hit = (!ca_off && overlap(dino, cactus)) || (!pt_off && overlap(dino, ptero)).
- Hit counter, updated on each RUN frame_tick:
  - hit=1: counter increments, saturating at 15.
  - hit=0: counter clears to 0.
  - When the counter reaches HIT_FRAMES on a frame_tick, the next cycle is DEAD.
- FSM:
  - START: KEY_START or KEY_JUMP press -> RUN. Hit counter cleared on entry to RUN.
  - RUN: hit counter reaches HIT_FRAMES -> DEAD. Holdoff counter loaded with HOLDOFF_FRAMES on entry.
  - DEAD: holdoff counter decrements on each frame_tick, stopping at 0. A KEY_START press while holdoff==0 -> START. Presses while holdoff>0 are ignored and are not remembered.
  - 2'b11 (illegal) -> START on the next cycle.
- A press and a frame_tick on the same cycle in START: the press wins, and no collision check is made that frame.
- Dead = (Game_State==10), decoded from the registered state. Dead is not asserted in the same cycle the transition is decided.
- Positions and keycode are treated as static within a cycle; no further input registering.

Optional Feature:
- Macro: GAME_INVINCIBLE_EN.
- Defined:
  - An internal invincible flag (reset 0) toggles on each press of keycode 8'h0C, in any state.
  - While the flag is set in RUN, the hit counter still counts, but the RUN->DEAD transition is suppressed.
  - Clearing the flag while the counter is at or above HIT_FRAMES causes DEAD on the next RUN frame_tick with hit=1.
- Undefined: no flag exists, keycode 8'h0C has no effect, and the logic is fully removed.

Decomposition:
- Shared package game_pkg:
  - typedef enum logic [1:0] game_state_t {GS_START=2'b00, GS_RUN=2'b01, GS_DEAD=2'b10}.
  - Keycode constants KEY_ENTER=8'h28, KEY_SPACE=8'h2C, KEY_I=8'h0C.
  - gamelogic and the sprite drawers will import the same enum.
- One natural sub-module, box_overlap: purely combinational 11-bit overlap compare, instantiated twice (cactus, pterosaur).

Test Plan:
- Reset and start: Reset pulse -> Game_State=00, Dead=0. keycode 00->28 -> Enter high one cycle, Game_State=01 one cycle later. Holding 28 for 100 cycles gives exactly one Enter pulse.
- Collision: RUN, dino (100,200), cactus (120,210) size 25x50, ca_off=0, then one frame_Clk edge -> Game_State=10 and Dead=1 within 5 Clk50 cycles.
- Edge touch and masking:
  - Cactus X=144 (100+44) -> no death over 10 frames.
  - Overlapping pterosaur with pt_off=1 -> no death.
- Holdoff: after death, KEY_START pressed at frames 5 and 29 -> stays DEAD. Pressed after 30 frame_ticks -> Game_State=00, then KEY_SPACE press -> 01.
- HIT_FRAMES=3: overlap for 2 frames, clear for 1, overlap for 2 -> alive. Overlap for 3 consecutive frames -> DEAD.
- Reset mid-DEAD during holdoff -> Game_State=00 asynchronously, with holdoff and hit counters at 0. With GAME_INVINCIBLE_EN: press 0C, overlap for 5 frames -> stays 01; press 0C again, next overlapping frame -> 10.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer, gamelogic and the
// sprite drawers.
//   game_state_t : 2-bit game state encoding (START / RUN / DEAD)
//   KEY_*        : USB HID keycodes used by the sequencer
//   HIT_CNT_MAX  : saturation value of the collision hit counter
package game_pkg;

    typedef enum logic [1:0] {
        GS_START = 2'b00,
        GS_RUN   = 2'b01,
        GS_DEAD  = 2'b10
    } game_state_t;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_I     = 8'h0C;

    localparam logic [3:0] HIT_CNT_MAX = 4'd15;

endpackage

// File: rtl/box_overlap.sv
// Axis-aligned bounding-box overlap test, purely combinational.
// Ports:
//   a_x, a_y, a_w, a_h : box A top-left and size (10 bit)
//   b_x, b_y, b_w, b_h : box B top-left and size (10 bit)
//   hit                : boxes share at least one pixel
// Sums are formed in 11 bits so position+size never wraps. Strict '<'
// means boxes that only touch along an edge do not overlap.
module box_overlap (
    input  logic [9:0] a_x,
    input  logic [9:0] a_y,
    input  logic [9:0] a_w,
    input  logic [9:0] a_h,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    input  logic [9:0] b_w,
    input  logic [9:0] b_h,
    output logic       hit
);

    logic [10:0] a_x2, a_y2, b_x2, b_y2;

    assign a_x2 = {1'b0, a_x} + {1'b0, a_w};
    assign a_y2 = {1'b0, a_y} + {1'b0, a_h};
    assign b_x2 = {1'b0, b_x} + {1'b0, b_w};
    assign b_y2 = {1'b0, b_y} + {1'b0, b_h};

    assign hit = ({1'b0, a_x} < b_x2) && ({1'b0, b_x} < a_x2) &&
                 ({1'b0, a_y} < b_y2) && ({1'b0, b_y} < a_y2);

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level game sequencer: START -> RUN -> DEAD -> START.
// Ports:
//   Clk50, Reset            : clock, async active-high reset
//   frame_Clk               : async frame strobe (one frame per rising edge)
//   keycode                 : current USB keycode (00 = none)
//   Dino_/Cactus_/Ptero_*   : sprite boxes for the collision check
//   ca_off, pt_off          : obstacle off screen, excluded from collision
//   Game_State, Dead        : registered state and its DEAD decode
//   Enter                   : one-cycle pulse per KEY_START press
//   frame_tick              : one-cycle pulse per synchronised frame edge
// Optional: define GAME_INVINCIBLE_EN to add an invincibility toggle on
// keycode 8'h0C that suppresses RUN->DEAD while set.
import game_pkg::*;

module game_state_ctrl #(
    parameter logic [7:0] KEY_START      = 8'h28,
    parameter logic [7:0] KEY_JUMP       = 8'h2C,
    parameter int         DINO_W         = 44,
    parameter int         DINO_H         = 47,
    parameter int         PT_W           = 46,
    parameter int         PT_H           = 40,
    parameter int         HIT_FRAMES     = 1,
    parameter int         HOLDOFF_FRAMES = 30
) (
    input  logic       Clk50,
    input  logic       Reset,
    input  logic       frame_Clk,
    input  logic [7:0] keycode,
    input  logic [9:0] Dino_PosX,
    input  logic [9:0] Dino_PosY,
    input  logic [9:0] Cactus_PosX,
    input  logic [9:0] Cactus_PosY,
    input  logic [9:0] Cactus_SizeX,
    input  logic [9:0] Cactus_SizeY,
    input  logic [9:0] Ptero_PosX,
    input  logic [9:0] Ptero_PosY,
    input  logic       ca_off,
    input  logic       pt_off,
    output logic [1:0] Game_State,
    output logic       Dead,
    output logic       Enter,
    output logic       frame_tick
);

    localparam logic [9:0] DINO_W10 = DINO_W[9:0];
    localparam logic [9:0] DINO_H10 = DINO_H[9:0];
    localparam logic [9:0] PT_W10   = PT_W[9:0];
    localparam logic [9:0] PT_H10   = PT_H[9:0];
    localparam logic [3:0] HIT_THR  = HIT_FRAMES[3:0];
    localparam logic [5:0] HOLD_LD  = HOLDOFF_FRAMES[5:0];

    game_state_t state, state_nx;
    logic [2:0]  fsync;
    logic [7:0]  key_prev;
    logic [3:0]  hit_cnt, hit_cnt_nx;
    logic [5:0]  holdoff;
    logic        press_start, press_jump;
    logic        ov_ca, ov_pt, hit, run_eval, kill;

    // frame_Clk: two synchroniser flops, third flop holds the previous
    // synchronised level for the rising-edge detect.
    always_ff @(posedge Clk50 or posedge Reset) begin
        if (Reset) begin
            fsync      <= 3'b000;
            frame_tick <= 1'b0;
        end else begin
            fsync      <= {fsync[1:0], frame_Clk};
            frame_tick <= fsync[1] & ~fsync[2];
        end
    end

    // Key edge detect: a held key gives exactly one press.
    always_ff @(posedge Clk50 or posedge Reset) begin
        if (Reset) begin
            key_prev <= 8'h00;
            Enter    <= 1'b0;
        end else begin
            key_prev <= keycode;
            Enter    <= press_start;
        end
    end

    assign press_start = (keycode == KEY_START) && (key_prev != KEY_START);
    assign press_jump  = (keycode == KEY_JUMP)  && (key_prev != KEY_JUMP);

    box_overlap u_ov_ca (
        .a_x(Dino_PosX),   .a_y(Dino_PosY),   .a_w(DINO_W10),     .a_h(DINO_H10),
        .b_x(Cactus_PosX), .b_y(Cactus_PosY), .b_w(Cactus_SizeX), .b_h(Cactus_SizeY),
        .hit(ov_ca)
    );

    box_overlap u_ov_pt (
        .a_x(Dino_PosX),  .a_y(Dino_PosY),  .a_w(DINO_W10), .a_h(DINO_H10),
        .b_x(Ptero_PosX), .b_y(Ptero_PosY), .b_w(PT_W10),   .b_h(PT_H10),
        .hit(ov_pt)
    );

    assign hit        = (!ca_off && ov_ca) || (!pt_off && ov_pt);
    assign hit_cnt_nx = !hit ? 4'd0 :
                        (hit_cnt == HIT_CNT_MAX) ? hit_cnt : hit_cnt + 4'd1;
    assign run_eval   = (state == GS_RUN) && frame_tick;

`ifdef GAME_INVINCIBLE_EN
    logic invinc;

    always_ff @(posedge Clk50 or posedge Reset) begin
        if (Reset)
            invinc <= 1'b0;
        else if ((keycode == KEY_I) && (key_prev != KEY_I))
            invinc <= ~invinc;
    end

    // '>=' so a counter that kept climbing while invincible still kills
    // on the first overlapping frame after the flag clears.
    assign kill = run_eval && (hit_cnt_nx >= HIT_THR) && !invinc;
`else
    assign kill = run_eval && (hit_cnt_nx >= HIT_THR);
`endif

    // State register
    always_ff @(posedge Clk50 or posedge Reset) begin
        if (Reset) state <= GS_START;
        else       state <= state_nx;
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            GS_START: if (press_start || press_jump)          state_nx = GS_RUN;
            GS_RUN:   if (kill)                               state_nx = GS_DEAD;
            GS_DEAD:  if (press_start && (holdoff == 6'd0))   state_nx = GS_START;
            default:                                          state_nx = GS_START;
        endcase
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        Game_State = state;
        Dead       = (state == GS_DEAD);
    end

    // Frame counters: hit streak in RUN, restart holdoff in DEAD.
    always_ff @(posedge Clk50 or posedge Reset) begin
        if (Reset) begin
            hit_cnt <= 4'd0;
            holdoff <= 6'd0;
        end else begin
            if (state_nx == GS_RUN && state != GS_RUN)
                hit_cnt <= 4'd0;
            else if (run_eval)
                hit_cnt <= hit_cnt_nx;

            if (state_nx == GS_DEAD && state != GS_DEAD)
                holdoff <= HOLD_LD;
            else if (state == GS_DEAD && frame_tick && holdoff != 6'd0)
                holdoff <= holdoff - 6'd1;
        end
    end

endmodule
